// File: rtl/mem_arbiter.sv
// mem_arbiter: hands the single memory controller to one of three requesters
// (icache fetch, store buffer, load buffer) by fixed priority with fetch
// anti-starvation, and holds the granted request stable until completion.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   rdy               global ready, 0 freezes all state
//   mc_rb             rollback, cancels a pending or in-flight load
//   io_full           IO output buffer full, blocks stores to IO space
//   ic_req_* / ic_done            fetch request channel and done pulse
//   st_req_* / st_done            store request channel and done pulse
//   ld_req_* / ld_done            load request channel and done pulse
//   mem_req_*                     registered request to the controller
//   mem_done                      controller completion pulse
//   mem_abort                     one-cycle pulse: controller drops the load
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned ROB_IDX_W    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 mc_rb,
  input  logic                 io_full,
  input  logic                 ic_req_valid,
  input  logic [ADDR_W-1:0]    ic_req_addr,
  output logic                 ic_done,
  input  logic                 st_req_valid,
  input  logic [ADDR_W-1:0]    st_req_addr,
  input  logic [31:0]          st_req_data,
  input  logic [3:0]           st_req_len,
  output logic                 st_done,
  input  logic                 ld_req_valid,
  input  logic [ADDR_W-1:0]    ld_req_addr,
  input  logic [3:0]           ld_req_len,
  input  logic                 ld_req_sext,
  input  logic [ROB_IDX_W-1:0] ld_req_src,
  output logic                 ld_done,
  output logic                 mem_req_valid,
  output logic [1:0]           mem_req_op,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [31:0]          mem_req_data,
  output logic [3:0]           mem_req_len,
  output logic                 mem_req_sext,
  output logic [ROB_IDX_W-1:0] mem_req_src,
  input  logic                 mem_done,
  output logic                 mem_abort
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [1:0] OP_FETCH = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [CNT_W-1:0]     wait_cnt, wait_cnt_nxt;
  logic                 valid_nxt;
  logic [1:0]           op_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [31:0]          data_nxt;
  logic [3:0]           len_nxt;
  logic                 sext_nxt;
  logic [ROB_IDX_W-1:0] src_nxt;
  logic                 ic_done_nxt, st_done_nxt, ld_done_nxt, abort_nxt;

  // Request qualification: starved fetch, unblocked store, non-rolled-back load
  logic fetch_starved, st_ok, ld_ok, gnt;
  logic [1:0] gnt_op;

  assign fetch_starved = ic_req_valid && (wait_cnt >= CNT_W'(STARVE_LIMIT));
  assign st_ok = st_req_valid && !((st_req_addr[17:16] == 2'b11) && io_full);
  assign ld_ok = ld_req_valid && !mc_rb;

  // Fixed-priority winner select
  always_comb begin
    gnt    = 1'b1;
    gnt_op = OP_FETCH;
    if (fetch_starved)     gnt_op = OP_FETCH;
    else if (st_ok)        gnt_op = OP_STORE;
    else if (ld_ok)        gnt_op = OP_LOAD;
    else if (ic_req_valid) gnt_op = OP_FETCH;
    else                   gnt    = 1'b0;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_op    <= 2'd0;
      mem_req_addr  <= '0;
      mem_req_data  <= 32'd0;
      mem_req_len   <= 4'd0;
      mem_req_sext  <= 1'b0;
      mem_req_src   <= '0;
      ic_done       <= 1'b0;
      st_done       <= 1'b0;
      ld_done       <= 1'b0;
      mem_abort     <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      mem_req_valid <= valid_nxt;
      mem_req_op    <= op_nxt;
      mem_req_addr  <= addr_nxt;
      mem_req_data  <= data_nxt;
      mem_req_len   <= len_nxt;
      mem_req_sext  <= sext_nxt;
      mem_req_src   <= src_nxt;
      ic_done       <= ic_done_nxt;
      st_done       <= st_done_nxt;
      ld_done       <= ld_done_nxt;
      mem_abort     <= abort_nxt;
    end
  end

  // Next state / next outputs; with rdy low everything holds and pulses drop
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    valid_nxt    = mem_req_valid;
    op_nxt       = mem_req_op;
    addr_nxt     = mem_req_addr;
    data_nxt     = mem_req_data;
    len_nxt      = mem_req_len;
    sext_nxt     = mem_req_sext;
    src_nxt      = mem_req_src;
    ic_done_nxt  = 1'b0;
    st_done_nxt  = 1'b0;
    ld_done_nxt  = 1'b0;
    abort_nxt    = 1'b0;
    if (rdy) begin
      case (state)
        S_IDLE: begin
          if (gnt && (gnt_op == OP_FETCH)) begin
            wait_cnt_nxt = '0;
          end else if (ic_req_valid && (wait_cnt < CNT_W'(STARVE_LIMIT))) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
          if (gnt) begin
            state_nxt = S_BUSY;
            valid_nxt = 1'b1;
            op_nxt    = gnt_op;
            data_nxt  = 32'd0;
            len_nxt   = 4'd0;
            sext_nxt  = 1'b0;
            src_nxt   = '0;
            case (gnt_op)
              OP_STORE: begin
                addr_nxt = st_req_addr;
                data_nxt = st_req_data;
                len_nxt  = st_req_len;
              end
              OP_LOAD: begin
                addr_nxt = ld_req_addr;
                len_nxt  = ld_req_len;
                sext_nxt = ld_req_sext;
                src_nxt  = ld_req_src;
              end
              default: addr_nxt = ic_req_addr;
            endcase
          end
        end
        S_BUSY: begin
          // Rollback of an owned load takes precedence over its completion
          if ((mem_req_op == OP_LOAD) && mc_rb) begin
            valid_nxt = 1'b0;
            abort_nxt = 1'b1;
            state_nxt = S_GAP;
          end else if (mem_done) begin
            valid_nxt = 1'b0;
            state_nxt = S_GAP;
            case (mem_req_op)
              OP_STORE: st_done_nxt = 1'b1;
              OP_LOAD:  ld_done_nxt = 1'b1;
              default:  ic_done_nxt = 1'b1;
            endcase
          end
        end
        S_GAP:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
